// File: rtl/irq_pending_latch.sv
// Request-edge latch in front of the 16-input priority encoder.
// Holds sticky pending bits and offers the encoded winner as a grant.
module irq_pending_latch #(
  parameter int          N         = 16,
  parameter int          IDX_W     = 4,
  parameter logic [7:0]  NONE_CODE = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  output logic [N-1:0]     pend_out,
  input  logic [7:0]       enc_code,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic [4:0]       pend_cnt,
  output logic             overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_q;
  logic [N-1:0]     req_prev_q;
  logic [N-1:0]     pend_q;
  logic [N-1:0]     pend_d;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic             ovf_q;
  logic             ovf_d;

  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic             hs;
  logic             enc_ok;
  logic [4:0]       cnt;

  assign rise = req_in & ~req_prev_q;
  assign hs   = valid_q & grant_ready;
  assign clr  = hs ? ({{(N-1){1'b0}}, 1'b1} << idx_q)
                   : '0;

  // rise is OR-ed in last so a fresh edge beats the clear
  assign pend_d = (pend_q & ~clr) | rise;
  assign ovf_d  = ovf_q | (|(rise & pend_q & ~clr));

  assign enc_ok = (enc_code != NONE_CODE)
               && (enc_code[7:IDX_W] == '0)
               && pend_q[enc_code[IDX_W-1:0]];

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + 5'(pend_q[i]);
    end
  end

  // line history reloads during reset too
  always_ff @(posedge clk) begin
    req_prev_q <= req_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enc_ok) begin
            idx_q   <= enc_code[IDX_W-1:0];
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pend_out    = pend_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign pend_cnt    = cnt;
  assign overflow    = ovf_q;

endmodule
